// File: rtl/scan_row_if.sv
// Row-protocol bundle between the scan controller (master) and the chip-side row receiver (slave).
// Carries the serial row stream, the strobes and the decoded status/address outputs.
interface scan_row_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              col_start;
  logic              row_data;
  logic              lrn;
  logic              g1;
  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic              clr_valid;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] row_active;
  logic              marker_err;
  logic              frame_err;
  logic              range_err;
  logic              seq_err;
  logic [15:0]       frame_cnt;

  modport master (
    output col_start, row_data, lrn, g1,
    input  disp_valid, disp_addr, clr_valid, clr_addr, row_active,
    input  marker_err, frame_err, range_err, seq_err, frame_cnt
  );

  modport slave (
    input  col_start, row_data, lrn, g1,
    output disp_valid, disp_addr, clr_valid, clr_addr, row_active,
    output marker_err, frame_err, range_err, seq_err, frame_cnt
  );
endinterface

// File: rtl/scan_row_rx.sv
// Chip-side decoder for the serial row protocol: frames on col_start, deserializes display and
// clear addresses, checks markers/range/sequence and double-buffers the active row on g1.
module scan_row_rx #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MARK_W    = 10,
  parameter int unsigned FRAME_LEN = 45,
  parameter int unsigned ROWS      = 720
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_row_if.slave bus
);

  localparam int unsigned SlotW = $clog2(FRAME_LEN);
  localparam logic [SlotW-1:0] DispLast  = SlotW'(ADDR_W - 1);
  localparam logic [SlotW-1:0] Mark0Last = SlotW'(ADDR_W + MARK_W - 1);
  localparam logic [SlotW-1:0] ClrLast   = SlotW'(2 * ADDR_W + MARK_W - 1);
  localparam logic [SlotW-1:0] Mark1Last = SlotW'(2 * (ADDR_W + MARK_W) - 1);
  localparam logic [SlotW-1:0] FrameLast = SlotW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {StIdle, StDisp, StMark0, StClr, StMark1, StTail} state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [ADDR_W-1:0] disp_sr_q, disp_sr_d, clr_sr_q, clr_sr_d;
  logic              mark_ok_q, mark_ok_d, lrn_seen_q, lrn_seen_d, have_prev_q, have_prev_d;
  logic              disp_valid_q, disp_valid_d, clr_valid_q, clr_valid_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d, clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] row_active_q, row_active_d;
  logic              marker_err_q, marker_err_d, frame_err_q, frame_err_d;
  logic              range_err_q, range_err_d, seq_err_q, seq_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              mark_ok_now;
  logic [31:0]       seq_inc, seq_exp;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    disp_sr_d    = disp_sr_q;
    clr_sr_d     = clr_sr_q;
    mark_ok_d    = mark_ok_q;
    lrn_seen_d   = lrn_seen_q;
    have_prev_d  = have_prev_q;
    disp_addr_d  = disp_addr_q;
    clr_addr_d   = clr_addr_q;
    frame_cnt_d  = frame_cnt_q;
    disp_valid_d = 1'b0;
    clr_valid_d  = 1'b0;
    marker_err_d = 1'b0;
    frame_err_d  = 1'b0;
    range_err_d  = 1'b0;
    seq_err_d    = 1'b0;
    row_active_d = bus.g1 ? disp_addr_q : row_active_q;
    mark_ok_now  = mark_ok_q & bus.row_data;
    // Expected successor of the previous display word, (prev + 1) mod ROWS.
    seq_inc      = 32'(disp_addr_q) + 32'd1;
    seq_exp      = (seq_inc >= ROWS) ? seq_inc - ROWS : seq_inc;

    if (bus.col_start) begin
      frame_err_d = (state_q != StIdle);
      state_d     = StDisp;
      slot_d      = SlotW'(1);
      disp_sr_d   = {bus.row_data, disp_sr_q[ADDR_W-1:1]};
      lrn_seen_d  = bus.lrn;
      mark_ok_d   = 1'b1;
    end else begin
      if (state_q != StIdle) slot_d = slot_q + SlotW'(1);
      case (state_q)
        StIdle: ;
        StDisp: begin
          disp_sr_d  = {bus.row_data, disp_sr_q[ADDR_W-1:1]};
          lrn_seen_d = lrn_seen_q | bus.lrn;
          if (slot_q == DispLast) state_d = StMark0;
        end
        StMark0: begin
          lrn_seen_d = lrn_seen_q | bus.lrn;
          mark_ok_d  = mark_ok_now;
          if (slot_q == Mark0Last) begin
            state_d   = StClr;
            mark_ok_d = 1'b1;
            if (mark_ok_now) begin
              disp_valid_d = 1'b1;
              disp_addr_d  = disp_sr_q;
              have_prev_d  = 1'b1;
              range_err_d  = (32'(disp_sr_q) >= ROWS);
              seq_err_d    = have_prev_q && (32'(disp_sr_q) != seq_exp);
            end else begin
              marker_err_d = 1'b1;
            end
          end
        end
        StClr: begin
          clr_sr_d   = {bus.row_data, clr_sr_q[ADDR_W-1:1]};
          lrn_seen_d = lrn_seen_q | bus.lrn;
          if (slot_q == ClrLast) state_d = StMark1;
        end
        StMark1: begin
          mark_ok_d = mark_ok_now;
          if (slot_q == Mark1Last) begin
            state_d = StTail;
            if (!mark_ok_now) begin
              marker_err_d = 1'b1;
            end else if (lrn_seen_q) begin
              clr_valid_d = 1'b1;
              clr_addr_d  = clr_sr_q;
              range_err_d = (32'(clr_sr_q) >= ROWS);
            end
          end
        end
        StTail: begin
          if (slot_q == FrameLast) begin
            state_d     = StIdle;
            slot_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      disp_sr_q    <= '0;
      clr_sr_q     <= '0;
      mark_ok_q    <= 1'b0;
      lrn_seen_q   <= 1'b0;
      have_prev_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_addr_q  <= '0;
      clr_valid_q  <= 1'b0;
      clr_addr_q   <= '0;
      row_active_q <= '0;
      marker_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      range_err_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      disp_sr_q    <= disp_sr_d;
      clr_sr_q     <= clr_sr_d;
      mark_ok_q    <= mark_ok_d;
      lrn_seen_q   <= lrn_seen_d;
      have_prev_q  <= have_prev_d;
      disp_valid_q <= disp_valid_d;
      disp_addr_q  <= disp_addr_d;
      clr_valid_q  <= clr_valid_d;
      clr_addr_q   <= clr_addr_d;
      row_active_q <= row_active_d;
      marker_err_q <= marker_err_d;
      frame_err_q  <= frame_err_d;
      range_err_q  <= range_err_d;
      seq_err_q    <= seq_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.clr_valid  = clr_valid_q;
  assign bus.clr_addr   = clr_addr_q;
  assign bus.row_active = row_active_q;
  assign bus.marker_err = marker_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.range_err  = range_err_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_scan_row_rx.sv
// Bench for scan_row_rx: directed frames drive the serial stream while a monitor pops
// hand-computed expected pulses (stamped with their cycle) from a scoreboard queue.
module tb_scan_row_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned base, base2;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned cyc;
    logic        dv;
    logic [9:0]  da;
    logic        cv;
    logic [9:0]  ca;
    logic        me, fe, re, se;
  } ev_t;

  ev_t exp_q[$];

  scan_row_if #(.ADDR_W(10)) bus ();

  scan_row_rx #(
    .ADDR_W   (10),
    .MARK_W   (10),
    .FRAME_LEN(45),
    .ROWS     (720)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: at each expected stamp compare every pulse and address; any other pulse is unexpected.
  always @(negedge clk) begin : monitor
    ev_t e;
    logic any;
    any = bus.disp_valid | bus.clr_valid | bus.marker_err | bus.frame_err | bus.range_err
        | bus.seq_err;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.disp_valid !== e.dv || bus.disp_addr !== e.da || bus.clr_valid !== e.cv ||
            bus.clr_addr !== e.ca || bus.marker_err !== e.me || bus.frame_err !== e.fe ||
            bus.range_err !== e.re || bus.seq_err !== e.se) begin
          n_err++;
          $display("FAIL event@%0d got dv=%b da=%0d cv=%b ca=%0d me=%b fe=%b re=%b se=%b, required dv=%b da=%0d cv=%b ca=%0d me=%b fe=%b re=%b se=%b",
                   cyc, bus.disp_valid, bus.disp_addr, bus.clr_valid, bus.clr_addr,
                   bus.marker_err, bus.frame_err, bus.range_err, bus.seq_err,
                   e.dv, e.da, e.cv, e.ca, e.me, e.fe, e.re, e.se);
        end
      end else if (any) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse@%0d got dv=%b cv=%b me=%b fe=%b re=%b se=%b, required none",
                 cyc, bus.disp_valid, bus.clr_valid, bus.marker_err, bus.frame_err,
                 bus.range_err, bus.seq_err);
      end
    end
  end

  task automatic push(input int unsigned c, input logic dv, input logic [9:0] da,
                      input logic cv, input logic [9:0] ca, input logic me, input logic fe,
                      input logic re, input logic se);
    ev_t e;
    e = '{c, dv, da, cv, ca, me, fe, re, se};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic zero_inputs();
    bus.col_start = 1'b0;
    bus.row_data  = 1'b0;
    bus.lrn       = 1'b0;
    bus.g1        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives slots 0..nslots-1 and returns at the negedge of slot nslots.
  task automatic send_frame(input logic [9:0] d, input logic [9:0] c, input int lrn_s,
                            input int g1_s, input int m0_bad, input int m1_bad,
                            input int nslots);
    for (int k = 0; k < nslots; k++) begin
      if (k > 0) @(negedge clk);
      bus.col_start = (k == 0);
      bus.lrn       = (k == lrn_s);
      bus.g1        = (k == g1_s);
      if (k < 10)      bus.row_data = d[k];
      else if (k < 20) bus.row_data = (k != m0_bad);
      else if (k < 30) bus.row_data = c[k-20];
      else if (k < 40) bus.row_data = (k != m1_bad);
      else             bus.row_data = k[0];
    end
    @(negedge clk);
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    idle(3);
    check("rst_pulses", {bus.disp_valid, bus.clr_valid, bus.marker_err, bus.frame_err,
                         bus.range_err, bus.seq_err}, 0);
    check("rst_disp_addr", bus.disp_addr, 0);
    check("rst_row_active", bus.row_active, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    rst_n = 1'b1;
    idle(20);  // no col_start: nothing may pulse

    // F1: disp 5, no lrn -> display only, clear dropped
    base = cyc;
    push(base + 20, 1, 5, 0, 0, 0, 0, 0, 0);
    send_frame(10'd5, 10'd300, -1, -1, -1, -1, 45);
    check("f1_clr_addr", bus.clr_addr, 0);
    check("f1_frame_cnt", bus.frame_cnt, 1);

    // F2 back-to-back: disp 6, clear 300, lrn at 19, g1 at 44
    base = cyc;
    push(base + 20, 1, 6, 0, 0, 0, 0, 0, 0);
    push(base + 40, 0, 6, 1, 300, 0, 0, 0, 0);
    send_frame(10'd6, 10'd300, 19, 44, -1, -1, 45);
    check("f2_row_active", bus.row_active, 6);
    check("f2_frame_cnt", bus.frame_cnt, 2);

    // F3: MARK0 bit 14 low -> marker_err, no display; clear 301 accepted (lrn at slot 0)
    base = cyc;
    push(base + 20, 0, 6, 0, 300, 1, 0, 0, 0);
    push(base + 40, 0, 6, 1, 301, 0, 0, 0, 0);
    send_frame(10'd7, 10'd301, 0, -1, 14, -1, 45);
    check("f3_frame_cnt", bus.frame_cnt, 3);

    // F4 aborted by col_start at slot 25, F5 decodes normally with lrn at last window slot
    base  = cyc;
    base2 = base + 25;
    push(base + 20, 1, 7, 0, 301, 0, 0, 0, 0);
    push(base + 26, 0, 7, 0, 301, 0, 1, 0, 0);
    push(base2 + 20, 1, 8, 0, 301, 0, 0, 0, 0);
    push(base2 + 40, 0, 8, 1, 200, 0, 0, 0, 0);
    send_frame(10'd7, 10'd100, 3, -1, -1, -1, 25);
    send_frame(10'd8, 10'd200, 29, -1, -1, -1, 45);
    check("f5_frame_cnt", bus.frame_cnt, 4);
    idle(3);

    // F6: 718 after 8 -> seq_err; lrn at slot 30 is outside the window -> no clear
    base = cyc;
    push(base + 20, 1, 718, 0, 200, 0, 0, 0, 1);
    send_frame(10'd718, 10'd50, 30, -1, -1, -1, 45);
    check("f6_clr_addr", bus.clr_addr, 200);

    // F7: 719, g1 at slot 22 latches the new row
    base = cyc;
    push(base + 20, 1, 719, 0, 200, 0, 0, 0, 0);
    send_frame(10'd719, 10'd50, -1, 22, -1, -1, 45);
    check("f7_row_active", bus.row_active, 719);

    // F8: wrap to 0 is in sequence; clear 900 out of range
    base = cyc;
    push(base + 20, 1, 0, 0, 200, 0, 0, 0, 0);
    push(base + 40, 0, 0, 1, 900, 0, 0, 1, 0);
    send_frame(10'd0, 10'd900, 5, -1, -1, -1, 45);

    // F9: 2 after 0 -> seq_err; MARK1 bit 35 low -> marker_err, clear suppressed
    base = cyc;
    push(base + 20, 1, 2, 0, 900, 0, 0, 0, 1);
    push(base + 40, 0, 2, 0, 900, 1, 0, 0, 0);
    send_frame(10'd2, 10'd10, 5, -1, -1, 35, 45);

    // F10: 800 out of range and out of sequence; disp_valid still asserted
    base = cyc;
    push(base + 20, 1, 800, 0, 900, 0, 0, 1, 1);
    send_frame(10'd800, 10'd10, -1, -1, -1, -1, 45);
    check("f10_frame_cnt", bus.frame_cnt, 9);
    idle(40);

    // F11 cut by reset at slot 12
    send_frame(10'd9, 10'd1, 2, 5, -1, -1, 12);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pulses", {bus.disp_valid, bus.clr_valid, bus.marker_err, bus.frame_err,
                            bus.range_err, bus.seq_err}, 0);
    check("midrst_disp_addr", bus.disp_addr, 0);
    check("midrst_clr_addr", bus.clr_addr, 0);
    check("midrst_row_active", bus.row_active, 0);
    check("midrst_frame_cnt", bus.frame_cnt, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // F12: first word after reset -> no seq_err
    base = cyc;
    push(base + 20, 1, 7, 0, 0, 0, 0, 0, 0);
    send_frame(10'd7, 10'd0, -1, -1, -1, -1, 45);
    check("f12_frame_cnt", bus.frame_cnt, 1);
    idle(5);
    check("pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_row_rx.md
Name: scan_row_rx

Overview:
- Receive-side decoder for the serial row protocol that the scan controller drives toward the microdisplay chip.
- Frames on col_start and deserializes the row_data stream into display and clear row addresses.
- Validates marker fields, address range and row sequence, and double-buffers the active display row, which is committed on g1.
- Used as the chip-side row driver model in system simulation and as an on-FPGA protocol monitor.

Parameters:
- ADDR_W, 10, width of the display and clear row address fields.
- MARK_W, 10, length of each all-ones marker field.
- FRAME_LEN, 45, slots per row frame; must satisfy FRAME_LEN >= 2*(ADDR_W+MARK_W)+1.
- ROWS, 720, number of physical rows; legal addresses are 0..ROWS-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col_start  in  1  frame sync; high during slot 0 of a frame
- row_data  in  1  serial row stream, one bit per clock
- lrn  in  1  clear-row request strobe
- g1  in  1  row latch strobe
- disp_valid  out  1  one-cycle pulse: display address received
- disp_addr  out  ADDR_W  last received display address
- clr_valid  out  1  one-cycle pulse: clear address accepted
- clr_addr  out  ADDR_W  last accepted clear address
- row_active  out  ADDR_W  display row committed on g1
- marker_err  out  1  one-cycle pulse: marker field not all ones
- frame_err  out  1  one-cycle pulse: col_start arrived mid-frame
- range_err  out  1  one-cycle pulse: address >= ROWS
- seq_err  out  1  one-cycle pulse: display address not previous+1 mod ROWS
- frame_cnt  out  16  count of complete frames, wraps at 65535

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs, shift registers, slot counter and flags reset to 0; state resets to IDLE.
- Wire format, slot k counted from the col_start cycle (k=0):
  - k=0..ADDR_W-1: display address, LSB first.
  - next MARK_W slots: ones.
  - next ADDR_W slots: clear address, LSB first.
  - next MARK_W slots: ones.
  - remaining slots up to FRAME_LEN-1: tail, content ignored.
- FSM states: IDLE, DISP, MARK0, CLR, MARK1, TAIL.
  - Slot counter increments every cycle outside IDLE.
  - Field transitions occur at the field boundaries above.
  - TAIL returns to IDLE after slot FRAME_LEN-1.
- col_start high in any state: slot counter = 0, state = DISP, and the current row_data is taken as bit 0.
  - If the state was not IDLE, frame_err pulses for one cycle and the partial frame is discarded (no valid pulses for it).
- Back-to-back frames: col_start on the cycle after slot FRAME_LEN-1 is legal and raises no error.
- col_start never arrives: the block stays in IDLE and emits no outputs.
- Marker checks: a marker is bad if any bit in its field is 0.
  - Evaluated at the end of the field; marker_err pulses the cycle after that field's last slot.
  - A bad MARK0 suppresses disp_valid; a bad MARK1 suppresses clr_valid.
- Display word commit, cycle after the MARK0 last slot if MARK0 is good:
  - disp_addr is updated and disp_valid pulses.
  - If addr >= ROWS, range_err pulses and disp_valid is still asserted.
  - seq_err pulses if addr != (prev_disp+1) mod ROWS. The check is skipped for the first word after reset. prev_disp is updated on every disp_valid.
- Clear word commit, cycle after the MARK1 last slot: requires MARK1 good and lrn sampled high at least once during slots 0..(2*ADDR_W+MARK_W-1) of the current frame.
  - clr_addr is updated and clr_valid pulses; range_err pulses on a clear address >= ROWS.
  - If lrn was not seen, the clear word is dropped silently.
  - The lrn-seen flag clears on col_start.
- row_active: loads disp_addr on g1, one cycle latency.
  - g1 coincident with disp_valid loads the old disp_addr (registered value).
- frame_cnt increments when TAIL completes, regardless of error flags.
- If range_err fires for both words in the same cycle, it is a single pulse.
- Reset mid-frame: everything returns to the reset values immediately; the next col_start starts clean.

Test Plan:
- Frame with disp=5, clear=300, lrn at slot 19, g1 at slot 44 -> disp_valid at slot 20 with disp_addr=5; clr_valid at slot 40 with clr_addr=300; row_active=5 the cycle after g1; frame_cnt=1.
- Same frame without lrn -> clr_valid never asserts and clr_addr stays 0; disp_valid still pulses.
- MARK0 bit 14 forced to 0 -> marker_err pulses at slot 20 and no disp_valid; clear word is still accepted if MARK1 is good.
- col_start reasserted at slot 25 -> frame_err pulse; no clr_valid for the aborted frame; the new frame decodes normally.
- Display addresses 718, 719, 0, then 2 with ROWS=720 -> no seq_err through the wrap from 719 to 0; seq_err on 2; disp=800 -> range_err.
- rst_n low at slot 12 then released; next frame disp=7 -> all outputs 0 during reset; disp_valid with 7 and no seq_err (first word after reset).
